// File: rtl/mips_multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALUOp codes,
// datapath select encodings, the control state enum and the ALU-control jr decode.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FUNCT_JR = 6'd8;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_RFORMAT = 2'b10;
    localparam logic [1:0] ALUOP_AND     = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ANDIEX = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13
    } state_t;

    // jr decode of the ALU control unit that sits beside this FSM in the datapath.
    function automatic logic alu_jr(input logic [1:0] alu_op, input logic [5:0] funct);
        return (alu_op == ALUOP_RFORMAT) && (funct == FUNCT_JR);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       jr;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, jr, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_write, alu_src_a, reg_dst, mem_to_reg, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

    modport slave (
        output opcode, jr, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_write, alu_src_a, reg_dst, mem_to_reg, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS: steps each instruction through its
// states and decodes datapath selects/enables, stalling memory states on mem_ready.
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_control_if.master  bus
);

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      state_next = S_EXEC;
                    OP_LW, OP_SW:  state_next = S_MEMADR;
                    OP_BEQ:        state_next = S_BRANCH;
                    OP_ADDI:       state_next = S_ADDIEX;
                    OP_ANDI:       state_next = S_ANDIEX;
                    OP_J:          state_next = S_JUMP;
                    OP_JAL:        state_next = S_JAL;
                    default:       state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            // jr finishes in EXEC so that a register-indirect jump never writes back.
            S_EXEC:   state_next = bus.jr ? S_FETCH : S_RWB;
            S_RWB:    state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_ADDIEX: state_next = S_IWB;
            S_ANDIEX: state_next = S_IWB;
            S_IWB:    state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_JAL:    state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.reg_dst       = REGDST_RT;
        bus.mem_to_reg    = MTR_ALUOUT;
        bus.alu_src_b     = SRCB_B;
        bus.alu_op        = ALUOP_ADD;
        bus.pc_source     = PCSRC_ALU;
        bus.illegal_op    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMM_SH2;
                case (bus.opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
                    OP_ADDI, OP_ANDI, OP_J, OP_JAL: bus.illegal_op = 1'b0;
                    default:                        bus.illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = MTR_MDR;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_RFORMAT;
                if (bus.jr) begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PCSRC_REGA;
                end
            end
            S_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = REGDST_RD;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALUOP_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_ANDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALUOP_AND;
            end
            S_IWB: begin
                bus.reg_write = 1'b1;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = PCSRC_JUMP;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = REGDST_RA;
                bus.mem_to_reg = MTR_PC;
            end
            default: ;
        endcase
        // Reset withdraws every request immediately so an aborted instruction leaves no partial write.
        if (reset) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.ir_write      = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.reg_write     = 1'b0;
            bus.illegal_op    = 1'b0;
        end
    end

    assign bus.state = state_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Cycle-by-cycle bench for the multicycle control FSM: each step queues the
// expected state/enables/selects and checks them against the DUT that cycle.
module tb_mips_multicycle_control;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Enables: {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, illegal_op}
    localparam logic [6:0] EN_NONE    = 7'b0000000;
    localparam logic [6:0] EN_FETCH   = 7'b1011000;
    localparam logic [6:0] EN_FWAIT   = 7'b0001000;
    localparam logic [6:0] EN_MRD     = 7'b0001000;
    localparam logic [6:0] EN_MWR     = 7'b0000100;
    localparam logic [6:0] EN_RW      = 7'b0000010;
    localparam logic [6:0] EN_PCW     = 7'b1000000;
    localparam logic [6:0] EN_PCWC    = 7'b0100000;
    localparam logic [6:0] EN_JAL     = 7'b1000010;
    localparam logic [6:0] EN_ILL     = 7'b0000001;

    // Selects: {iord, alu_src_a, reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source}
    localparam logic [11:0] SEL_FETCH  = 12'b0_0_00_00_01_00_00;
    localparam logic [11:0] SEL_DECODE = 12'b0_0_00_00_11_00_00;
    localparam logic [11:0] SEL_MEMADR = 12'b0_1_00_00_10_00_00;
    localparam logic [11:0] SEL_MEMACC = 12'b1_0_00_00_00_00_00;
    localparam logic [11:0] SEL_MEMWB  = 12'b0_0_00_01_00_00_00;
    localparam logic [11:0] SEL_EXEC   = 12'b0_1_00_00_00_10_00;
    localparam logic [11:0] SEL_EXECJR = 12'b0_1_00_00_00_10_11;
    localparam logic [11:0] SEL_RWB    = 12'b0_0_01_00_00_00_00;
    localparam logic [11:0] SEL_BRANCH = 12'b0_1_00_00_00_01_01;
    localparam logic [11:0] SEL_ADDIEX = 12'b0_1_00_00_10_00_00;
    localparam logic [11:0] SEL_ANDIEX = 12'b0_1_00_00_10_11_00;
    localparam logic [11:0] SEL_IWB    = 12'b0_0_00_00_00_00_00;
    localparam logic [11:0] SEL_JUMP   = 12'b0_0_00_00_00_00_10;
    localparam logic [11:0] SEL_JAL    = 12'b0_0_10_10_00_00_10;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [6:0]  en;
        logic [11:0] sel;
        bit          chk_sel;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare mid-cycle, then advance.
    task automatic step(input string tag, input logic rst, input logic [5:0] op,
                        input logic j, input logic mr, input logic [3:0] st,
                        input logic [6:0] en, input logic [11:0] sel, input bit cs);
        exp_t e;
        exp_t got_e;
        logic [6:0]  got_en;
        logic [11:0] got_sel;
        reset         = rst;
        bus.opcode    = op;
        bus.jr        = j;
        bus.mem_ready = mr;
        e.tag = tag; e.st = st; e.en = en; e.sel = sel; e.chk_sel = cs;
        sb.push_back(e);
        #1;
        got_en  = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read,
                   bus.mem_write, bus.reg_write, bus.illegal_op};
        got_sel = {bus.iord, bus.alu_src_a, bus.reg_dst, bus.mem_to_reg,
                   bus.alu_src_b, bus.alu_op, bus.pc_source};
        got_e = sb.pop_front();
        check({got_e.tag, ".state"}, 32'(bus.state), 32'(got_e.st));
        check({got_e.tag, ".en"}, 32'(got_en), 32'(got_e.en));
        if (got_e.chk_sel) check({got_e.tag, ".sel"}, 32'(got_sel), 32'(got_e.sel));
        $display("[TB] %-12s state=%0d en=%b sel=%b", got_e.tag, bus.state, got_en, got_sel);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.opcode    = 6'd0;
        bus.jr        = 1'b0;
        bus.mem_ready = 1'b1;
        reset         = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Enables forced low while in reset; state already FETCH.
        step("rst_hold", 1, OP_LW, 0, 1, S_FETCH, EN_NONE, SEL_FETCH, 0);

        // lw, zero-wait: 5 cycles.
        step("lw_fetch",  0, OP_LW, 0, 1, S_FETCH,  EN_FETCH, SEL_FETCH,  1);
        step("lw_decode", 0, OP_LW, 0, 1, S_DECODE, EN_NONE,  SEL_DECODE, 1);
        step("lw_memadr", 0, OP_LW, 0, 1, S_MEMADR, EN_NONE,  SEL_MEMADR, 1);
        step("lw_memrd",  0, OP_LW, 0, 1, S_MEMRD,  EN_MRD,   SEL_MEMACC, 1);
        step("lw_memwb",  0, OP_LW, 1, 1, S_MEMWB,  EN_RW,    SEL_MEMWB,  1);

        // sw with a wait in FETCH, then two wait cycles in MEMWR.
        step("sw_fwait",  0, OP_SW, 0, 0, S_FETCH,  EN_FWAIT, SEL_FETCH,  1);
        step("sw_fetch",  0, OP_SW, 0, 1, S_FETCH,  EN_FETCH, SEL_FETCH,  1);
        step("sw_decode", 0, OP_SW, 0, 0, S_DECODE, EN_NONE,  SEL_DECODE, 1);
        step("sw_memadr", 0, OP_SW, 0, 0, S_MEMADR, EN_NONE,  SEL_MEMADR, 1);
        step("sw_wait1",  0, OP_SW, 0, 0, S_MEMWR,  EN_MWR,   SEL_MEMACC, 1);
        step("sw_wait2",  0, OP_SW, 0, 0, S_MEMWR,  EN_MWR,   SEL_MEMACC, 1);
        step("sw_memwr",  0, OP_SW, 0, 1, S_MEMWR,  EN_MWR,   SEL_MEMACC, 1);

        // jr: finishes in EXEC, never reaches RWB.
        step("jr_fetch",  0, OP_RTYPE, 0, 1, S_FETCH,  EN_FETCH, SEL_FETCH,  1);
        step("jr_decode", 0, OP_RTYPE, 1, 1, S_DECODE, EN_NONE,  SEL_DECODE, 1);
        step("jr_exec",   0, OP_RTYPE, 1, 1, S_EXEC,   EN_PCW,   SEL_EXECJR, 1);

        // R-type without jr.
        step("r_fetch",   0, OP_RTYPE, 0, 1, S_FETCH,  EN_FETCH, SEL_FETCH,  1);
        step("r_decode",  0, OP_RTYPE, 0, 1, S_DECODE, EN_NONE,  SEL_DECODE, 1);
        step("r_exec",    0, OP_RTYPE, 0, 1, S_EXEC,   EN_NONE,  SEL_EXEC,   1);
        step("r_rwb",     0, OP_RTYPE, 1, 0, S_RWB,    EN_RW,    SEL_RWB,    1);

        // beq
        step("beq_fetch",  0, OP_BEQ, 0, 1, S_FETCH,  EN_FETCH, SEL_FETCH,  1);
        step("beq_decode", 0, OP_BEQ, 0, 1, S_DECODE, EN_NONE,  SEL_DECODE, 1);
        step("beq_branch", 0, OP_BEQ, 0, 1, S_BRANCH, EN_PCWC,  SEL_BRANCH, 1);

        // addi / andi
        step("addi_fetch",  0, OP_ADDI, 0, 1, S_FETCH,  EN_FETCH, SEL_FETCH,  1);
        step("addi_decode", 0, OP_ADDI, 0, 1, S_DECODE, EN_NONE,  SEL_DECODE, 1);
        step("addi_ex",     0, OP_ADDI, 0, 1, S_ADDIEX, EN_NONE,  SEL_ADDIEX, 1);
        step("addi_wb",     0, OP_ADDI, 0, 1, S_IWB,    EN_RW,    SEL_IWB,    1);
        step("andi_fetch",  0, OP_ANDI, 0, 1, S_FETCH,  EN_FETCH, SEL_FETCH,  1);
        step("andi_decode", 0, OP_ANDI, 0, 1, S_DECODE, EN_NONE,  SEL_DECODE, 1);
        step("andi_ex",     0, OP_ANDI, 0, 1, S_ANDIEX, EN_NONE,  SEL_ANDIEX, 1);
        step("andi_wb",     0, OP_ANDI, 0, 1, S_IWB,    EN_RW,    SEL_IWB,    1);

        // j / jal
        step("j_fetch",    0, OP_J,   0, 1, S_FETCH,  EN_FETCH, SEL_FETCH,  1);
        step("j_decode",   0, OP_J,   0, 1, S_DECODE, EN_NONE,  SEL_DECODE, 1);
        step("j_jump",     0, OP_J,   0, 1, S_JUMP,   EN_PCW,   SEL_JUMP,   1);
        step("jal_fetch",  0, OP_JAL, 0, 1, S_FETCH,  EN_FETCH, SEL_FETCH,  1);
        step("jal_decode", 0, OP_JAL, 0, 1, S_DECODE, EN_NONE,  SEL_DECODE, 1);
        step("jal_jal",    0, OP_JAL, 0, 1, S_JAL,    EN_JAL,   SEL_JAL,    1);

        // Illegal opcode: one-cycle pulse in DECODE, then FETCH.
        step("ill_fetch",  0, 6'd63, 0, 1, S_FETCH,  EN_FETCH, SEL_FETCH,  1);
        step("ill_decode", 0, 6'd63, 0, 1, S_DECODE, EN_ILL,   SEL_DECODE, 1);
        step("ill_after",  0, 6'd63, 0, 0, S_FETCH,  EN_FWAIT, SEL_FETCH,  1);

        // lw aborted by a 3-cycle reset while stalled in MEMRD.
        step("ab_fetch",  0, OP_LW, 0, 1, S_FETCH,  EN_FETCH, SEL_FETCH,  1);
        step("ab_decode", 0, OP_LW, 0, 1, S_DECODE, EN_NONE,  SEL_DECODE, 1);
        step("ab_memadr", 0, OP_LW, 0, 1, S_MEMADR, EN_NONE,  SEL_MEMADR, 1);
        step("ab_memrd",  0, OP_LW, 0, 0, S_MEMRD,  EN_MRD,   SEL_MEMACC, 1);
        step("ab_rst1",   1, OP_LW, 0, 1, S_MEMRD,  EN_NONE,  SEL_MEMACC, 0);
        step("ab_rst2",   1, OP_LW, 0, 1, S_FETCH,  EN_NONE,  SEL_FETCH,  0);
        step("ab_rst3",   1, OP_LW, 0, 1, S_FETCH,  EN_NONE,  SEL_FETCH,  0);
        step("ab_rel",    0, OP_LW, 0, 0, S_FETCH,  EN_FWAIT, SEL_FETCH,  1);
        step("ab_refetch",0, OP_LW, 0, 1, S_FETCH,  EN_FETCH, SEL_FETCH,  1);
        step("ab_decode2",0, OP_LW, 0, 1, S_DECODE, EN_NONE,  SEL_DECODE, 1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
